// File: rtl/spectrum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spectrum_pkg
// Description : Shared constants, state encoding and config opcodes for the
//               spectrum display FFT sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package spectrum_pkg;

  localparam int FFT_LEN   = 1024;  // FFT points per frame
  localparam int BIN_W     = 10;    // log2(FFT_LEN)
  localparam int ADDR_W    = 9;     // spectrum RAM address width
  localparam int FRAME_MAX = 44;    // frame index wraps FRAME_MAX -> 0
  localparam int TIMEOUT   = 4096;  // cycles allowed before first output beat
  localparam int FRAME_W   = 6;
  localparam int DECIM_W   = 4;
  localparam int WR_DELAY  = 2;     // lower-path data pipeline depth

  localparam logic CFG_FFT  = 1'b1;
  localparam logic CFG_IFFT = 1'b0;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CFG_F  = 3'd1;
  localparam logic [2:0] S_WAIT_F = 3'd2;
  localparam logic [2:0] S_STRM_F = 3'd3;
  localparam logic [2:0] S_CFG_I  = 3'd4;
  localparam logic [2:0] S_WAIT_I = 3'd5;
  localparam logic [2:0] S_STRM_I = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_CFG_F  = S_CFG_F,
    ST_WAIT_F = S_WAIT_F,
    ST_STRM_F = S_STRM_F,
    ST_CFG_I  = S_CFG_I,
    ST_WAIT_I = S_WAIT_I,
    ST_STRM_I = S_STRM_I,
    ST_DONE   = S_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spectrum_wr_delay.sv
`default_nettype none
// ============================================================================
// Module      : spectrum_wr_delay
// Description : N-stage {enable, address} delay line that keeps the lower
//               spectrum RAM write strobe aligned with its data pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module spectrum_wr_delay
  import spectrum_pkg::*;
#(
  parameter int STAGES = WR_DELAY,
  parameter int DATA_W = ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_addr,
  output logic              o_en,
  output logic [DATA_W-1:0] o_addr
);

  logic [STAGES-1:0] en_q;
  logic [DATA_W-1:0] addr_q [STAGES];

  // Shift register; free-running so it drains regardless of the sequencer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      en_q[0]   <= i_en;
      addr_q[0] <= i_addr;
      for (int i = 1; i < STAGES; i++) begin
        en_q[i]   <= en_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign o_en   = en_q[STAGES-1];
  assign o_addr = addr_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spectrum_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spectrum_frame_ctrl
// Description : Per-frame FFT/IFFT sequencer for the spectrum display path:
//               issues config beats, counts output beats, drives the two
//               spectrum RAM write ports, applies decimation/freeze and keeps
//               the written-frame index.
// Revision    : 1.0 - initial release
// ============================================================================
module spectrum_frame_ctrl
  import spectrum_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_req,
  input  logic               ifft_en,
  input  logic [DECIM_W-1:0] decim,
  input  logic               freeze,
  output logic               cfg_tvalid,
  output logic               cfg_tdata,
  input  logic               cfg_tready,
  input  logic               xk_tvalid,
  input  logic               xk_tlast,
  output logic               wr_en_ram1,
  output logic [ADDR_W-1:0]  wr_addr_ram1,
  output logic               wr_en_ram2,
  output logic [ADDR_W-1:0]  wr_addr_ram2,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               busy,
  output logic               frame_done,
  output logic               err
);

  localparam int TMO_W = $clog2(TIMEOUT);

  localparam logic [BIN_W-1:0]   LAST_BEAT    = BIN_W'(FFT_LEN - 1);
  localparam logic [BIN_W-1:0]   LAST_WR_BEAT = BIN_W'(1 << ADDR_W);
  localparam logic [BIN_W-1:0]   BEAT_ONE     = BIN_W'(1);
  localparam logic [TMO_W-1:0]   TMO_LAST     = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]   TMO_ONE      = TMO_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_LAST   = FRAME_W'(FRAME_MAX);
  localparam logic [FRAME_W-1:0] FRAME_ONE    = FRAME_W'(1);
  localparam logic [DECIM_W-1:0] DECIM_ONE    = DECIM_W'(1);

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   beat_q, beat_d;          // index of the next expected beat
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               ifft_q, ifft_d;          // IFFT pass requested for this frame
  logic               wr_frame_q, wr_frame_d;  // this frame updates the display
  logic               err_seen_q, err_seen_d;  // frame ended on a length error
  logic [DECIM_W-1:0] decim_lat_q, decim_lat_d;
  logic [DECIM_W-1:0] decim_cnt_q, decim_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               cfg_tvalid_q, cfg_tvalid_d;
  logic               cfg_tdata_q, cfg_tdata_d;
  logic               wr_en1_q, wr_en1_d;
  logic [ADDR_W-1:0]  wr_addr1_q, wr_addr1_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               err_q, err_d;

  logic at_last_beat;
  logic in_wr_range;

  assign at_last_beat = (beat_q == LAST_BEAT);
  // Bin 0 (DC) and the mirrored upper half are never displayed
  assign in_wr_range  = (beat_q >= BEAT_ONE) && (beat_q <= LAST_WR_BEAT);

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    ifft_d      = ifft_q;
    wr_frame_d  = wr_frame_q;
    err_seen_d  = err_seen_q;
    decim_lat_d = decim_lat_q;
    decim_cnt_d = decim_cnt_q;
    frame_cnt_d = frame_cnt_q;
    wr_en1_d    = 1'b0;
    wr_addr1_d  = wr_addr1_q;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_req) begin
          state_d     = ST_CFG_F;
          ifft_d      = ifft_en;
          wr_frame_d  = !freeze && (decim_cnt_q == '0);
          decim_lat_d = decim;
          err_seen_d  = 1'b0;
          beat_d      = '0;
          tmo_d       = '0;
        end
      end

      ST_CFG_F, ST_CFG_I: begin
        if (cfg_tready) begin
          state_d = (state_q == ST_CFG_F) ? ST_WAIT_F : ST_WAIT_I;
          tmo_d   = '0;
        end
      end

      ST_WAIT_F, ST_WAIT_I: begin
        if (xk_tvalid) begin
          // This beat is bin 0; the next one seen will be bin 1
          state_d = (state_q == ST_WAIT_F) ? ST_STRM_F : ST_STRM_I;
          beat_d  = BEAT_ONE;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      ST_STRM_F, ST_STRM_I: begin
        if (xk_tvalid) begin
          if ((state_q == ST_STRM_F) && wr_frame_q && in_wr_range) begin
            wr_en1_d   = 1'b1;
            wr_addr1_d = ADDR_W'(beat_q - BEAT_ONE);
          end
          if (xk_tlast || at_last_beat) begin
            // Either an early tlast or a missing one closes the pass with an error
            if (xk_tlast != at_last_beat) begin
              err_d      = 1'b1;
              err_seen_d = 1'b1;
            end
            beat_d  = '0;
            state_d = ((state_q == ST_STRM_F) && ifft_q) ? ST_CFG_I : ST_DONE;
          end else begin
            beat_d = beat_q + BEAT_ONE;
          end
        end
      end

      ST_DONE: begin
        state_d     = ST_IDLE;
        decim_cnt_d = (decim_cnt_q == decim_lat_q) ? '0 : decim_cnt_q + DECIM_ONE;
        if (wr_frame_q && !err_seen_q) begin
          frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + FRAME_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cfg_tvalid_d = (state_d == ST_CFG_F) || (state_d == ST_CFG_I);
    cfg_tdata_d  = (state_d == ST_CFG_F) ? CFG_FFT : CFG_IFFT;
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      tmo_q        <= '0;
      ifft_q       <= 1'b0;
      wr_frame_q   <= 1'b0;
      err_seen_q   <= 1'b0;
      decim_lat_q  <= '0;
      decim_cnt_q  <= '0;
      frame_cnt_q  <= '0;
      cfg_tvalid_q <= 1'b0;
      cfg_tdata_q  <= 1'b0;
      wr_en1_q     <= 1'b0;
      wr_addr1_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      tmo_q        <= tmo_d;
      ifft_q       <= ifft_d;
      wr_frame_q   <= wr_frame_d;
      err_seen_q   <= err_seen_d;
      decim_lat_q  <= decim_lat_d;
      decim_cnt_q  <= decim_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      cfg_tvalid_q <= cfg_tvalid_d;
      cfg_tdata_q  <= cfg_tdata_d;
      wr_en1_q     <= wr_en1_d;
      wr_addr1_q   <= wr_addr1_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  spectrum_wr_delay #(
    .STAGES (WR_DELAY),
    .DATA_W (ADDR_W)
  ) u_ram2_delay (
    .clk    (clk),
    .rst    (rst),
    .i_en   (wr_en1_q),
    .i_addr (wr_addr1_q),
    .o_en   (wr_en_ram2),
    .o_addr (wr_addr_ram2)
  );

  assign cfg_tvalid   = cfg_tvalid_q;
  assign cfg_tdata    = cfg_tdata_q;
  assign wr_en_ram1   = wr_en1_q;
  assign wr_addr_ram1 = wr_addr1_q;
  assign frame_cnt    = frame_cnt_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spectrum_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spectrum_frame_ctrl
// Description : Self-checking bench for spectrum_frame_ctrl: table of frame
//               scenarios, hand-written timeout / reset / wrap sequences and
//               randomized frames against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spectrum_frame_ctrl;

  localparam int FFT_LEN   = 1024;
  localparam int RAM_BINS  = 512;
  localparam int FRAME_MAX = 44;
  localparam int TIMEOUT   = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_req = 1'b0;
  logic       ifft_en = 1'b0;
  logic [3:0] decim = 4'd0;
  logic       freeze = 1'b0;
  logic       cfg_tready = 1'b0;
  logic       xk_tvalid = 1'b0;
  logic       xk_tlast = 1'b0;
  logic       cfg_tvalid, cfg_tdata;
  logic       wr_en_ram1, wr_en_ram2;
  logic [8:0] wr_addr_ram1, wr_addr_ram2;
  logic [5:0] frame_cnt;
  logic       busy, frame_done, err;

  int n_cmp = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int wr1_cnt = 0;
  int m_fc = 0;   // model: written-frame index
  int m_dc = 0;   // model: frames seen since last displayed frame

  logic [1:0] h_en;
  logic [8:0] h_addr [2];

  typedef struct {
    int decim; bit freeze; bit ifft; int tl_f; int tl_i; int rdy;
    int exp_wr; int exp_fc; int exp_err;
  } vec_t;
  vec_t vecs[15];

  spectrum_frame_ctrl dut (
    .clk(clk), .rst(rst), .frame_req(frame_req), .ifft_en(ifft_en),
    .decim(decim), .freeze(freeze), .cfg_tvalid(cfg_tvalid),
    .cfg_tdata(cfg_tdata), .cfg_tready(cfg_tready), .xk_tvalid(xk_tvalid),
    .xk_tlast(xk_tlast), .wr_en_ram1(wr_en_ram1), .wr_addr_ram1(wr_addr_ram1),
    .wr_en_ram2(wr_en_ram2), .wr_addr_ram2(wr_addr_ram2),
    .frame_cnt(frame_cnt), .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_100_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Event counters and the ram2 = ram1-delayed-by-two check
  always @(negedge clk) begin
    if (rst) begin
      h_en = 2'b00;
      h_addr[0] = '0;
      h_addr[1] = '0;
    end else begin
      if (err) err_cnt++;
      if (frame_done) done_cnt++;
      if (wr_en_ram1) wr1_cnt++;
      if (h_en[1] || wr_en_ram2) begin
        chk("ram2_en", wr_en_ram2, h_en[1]);
        chk("ram2_addr", wr_addr_ram2, h_addr[1]);
      end
      h_en[1] = h_en[0];
      h_addr[1] = h_addr[0];
      h_en[0] = wr_en_ram1;
      h_addr[0] = wr_addr_ram1;
    end
  end

  // Wait for a config beat, hold off acceptance for rdy cycles, then accept
  task automatic do_cfg(input bit fwd, input int rdy);
    int n;
    n = 0;
    while (!cfg_tvalid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_valid", cfg_tvalid, 1);
    frame_req = 1'b0;
    for (int i = 0; i < rdy; i++) begin
      chk("cfg_hold_valid", cfg_tvalid, 1);
      chk("cfg_hold_data", cfg_tdata, fwd);
      @(negedge clk);
    end
    chk("cfg_data", cfg_tdata, fwd);
    chk("cfg_busy", busy, 1);
    cfg_tready = 1'b1;
    @(negedge clk);
    cfg_tready = 1'b0;
    chk("cfg_drop", cfg_tvalid, 0);
  endtask

  // Drive beats 0..last (tl < 0: no tlast, run to FFT_LEN-1) and check ram1 writes
  task automatic do_stream(input bit fwd, input bit wr, input int tl, input int gap, input int pre);
    int k, last, bk;
    bit g, exp_en;
    for (int i = 0; i < pre; i++) @(negedge clk);
    last = (tl >= 0) ? tl : FFT_LEN - 1;
    k = 0;
    while (k <= last) begin
      g = (k > 0) && (gap > 0) && (int'($urandom_range(99)) < gap);
      bk = -1;
      if (g) begin
        xk_tvalid = 1'b0;
        xk_tlast = 1'b0;
      end else begin
        xk_tvalid = 1'b1;
        xk_tlast = (k == tl);
        bk = k;
        k++;
      end
      @(negedge clk);
      exp_en = fwd && wr && (bk >= 1) && (bk <= RAM_BINS);
      chk("wr1_en", wr_en_ram1, exp_en);
      if (exp_en) chk("wr1_addr", wr_addr_ram1, bk - 1);
    end
    xk_tvalid = 1'b0;
    xk_tlast = 1'b0;
  endtask

  task automatic run_frame(input int dv, input bit frz, input bit ifd, input int tl_f,
                           input int tl_i, input int rdy, input int gap, input int pre,
                           input bit wr, input int exp_wr, input int exp_fc, input int exp_err);
    int done0, err0, wr0, n;
    done0 = done_cnt; err0 = err_cnt; wr0 = wr1_cnt;
    decim = dv[3:0];
    freeze = frz;
    ifft_en = ifd;
    frame_req = 1'b1;
    do_cfg(1'b1, rdy);
    // Mid-frame changes must not affect this frame
    decim = ~decim;
    freeze = ~freeze;
    ifft_en = ~ifft_en;
    do_stream(1'b1, wr, tl_f, gap, pre);
    if (ifd) begin
      do_cfg(1'b0, rdy);
      do_stream(1'b0, 1'b0, tl_i, gap, pre);
    end
    n = 0;
    while (!frame_done && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", frame_done, 1);
    @(negedge clk);
    #1;
    chk("frame_cnt", frame_cnt, exp_fc);
    chk("idle_busy", busy, 0);
    chk("done_pulses", done_cnt - done0, 1);
    chk("err_pulses", err_cnt - err0, exp_err);
    chk("ram1_writes", wr1_cnt - wr0, exp_wr);
  endtask

  initial begin
    int n, done0, d, tf, ti, nwr, nerr;
    bit fz, ifd, wr, bad;

    vecs[0]  = '{0, 0, 0, 1023, 1023, 0,  512, 1, 0};
    vecs[1]  = '{0, 0, 0, 1023, 1023, 10, 512, 2, 0};
    vecs[2]  = '{0, 0, 1, 1023, 1023, 3,  512, 3, 0};
    vecs[3]  = '{2, 0, 0, 1023, 1023, 0,  512, 4, 0};
    vecs[4]  = '{2, 0, 0, 1023, 1023, 0,  0,   4, 0};
    vecs[5]  = '{2, 0, 0, 1023, 1023, 0,  0,   4, 0};
    vecs[6]  = '{2, 0, 0, 1023, 1023, 0,  512, 5, 0};
    vecs[7]  = '{2, 0, 0, 1023, 1023, 0,  0,   5, 0};
    vecs[8]  = '{2, 0, 0, 1023, 1023, 0,  0,   5, 0};
    vecs[9]  = '{0, 1, 0, 1023, 1023, 0,  0,   5, 0};
    vecs[10] = '{0, 0, 0, 1023, 1023, 0,  512, 6, 0};
    vecs[11] = '{0, 0, 0, 700,  1023, 0,  512, 6, 1};
    vecs[12] = '{0, 0, 0, -1,   1023, 0,  512, 6, 1};
    vecs[13] = '{0, 0, 0, 300,  1023, 0,  300, 6, 1};
    vecs[14] = '{0, 0, 1, 1023, 500,  2,  512, 6, 1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cfg_tvalid", cfg_tvalid, 0);
    chk("rst_cfg_tdata", cfg_tdata, 0);
    chk("rst_wr_en_ram1", wr_en_ram1, 0);
    chk("rst_wr_addr_ram1", wr_addr_ram1, 0);
    chk("rst_wr_en_ram2", wr_en_ram2, 0);
    chk("rst_wr_addr_ram2", wr_addr_ram2, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    // Table-driven frame scenarios
    for (int i = 0; i < 15; i++) begin
      run_frame(vecs[i].decim, vecs[i].freeze, vecs[i].ifft, vecs[i].tl_f, vecs[i].tl_i,
                vecs[i].rdy, 0, 0, vecs[i].exp_wr != 0, vecs[i].exp_wr,
                vecs[i].exp_fc, vecs[i].exp_err);
    end
    m_fc = 6;
    m_dc = 0;

    // First-beat timeout in WAIT_F
    done0 = done_cnt;
    decim = 4'd0; freeze = 1'b0; ifft_en = 1'b0; frame_req = 1'b1;
    do_cfg(1'b1, 0);
    n = 0;
    while (!err && n < TIMEOUT + 16) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, TIMEOUT);
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("tmo_err_pulse", err, 0);
    chk("tmo_no_done", done_cnt - done0, 0);
    chk("tmo_frame_cnt", frame_cnt, m_fc);

    // Randomized frames against the frame-level model
    for (int r = 0; r < 6; r++) begin
      d = int'($urandom_range(3));
      fz = ($urandom_range(3) == 0);
      ifd = ($urandom_range(2) == 0);
      tf = ($urandom_range(3) == 0) ? int'($urandom_range(1022, 1)) : FFT_LEN - 1;
      ti = ($urandom_range(3) == 0) ? int'($urandom_range(1022, 1)) : FFT_LEN - 1;
      wr = !fz && (m_dc == 0);
      bad = (tf != FFT_LEN - 1) || (ifd && ti != FFT_LEN - 1);
      nerr = ((tf != FFT_LEN - 1) ? 1 : 0) + ((ifd && ti != FFT_LEN - 1) ? 1 : 0);
      nwr = wr ? ((tf < RAM_BINS) ? tf : RAM_BINS) : 0;
      if (wr && !bad) m_fc = (m_fc + 1) % (FRAME_MAX + 1);
      m_dc = (m_dc == d) ? 0 : (m_dc + 1) % 16;
      run_frame(d, fz, ifd, tf, ti, int'($urandom_range(4)), 8, int'($urandom_range(5)),
                wr, nwr, m_fc, nerr);
    end

    // Reset in the middle of the write burst
    decim = 4'd0; freeze = 1'b0; ifft_en = 1'b0; frame_req = 1'b1;
    do_cfg(1'b1, 0);
    for (int i = 0; i < 100; i++) begin
      xk_tvalid = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_wr_en_ram1", wr_en_ram1, 0);
    chk("mrst_wr_en_ram2", wr_en_ram2, 0);
    chk("mrst_frame_cnt", frame_cnt, 0);
    chk("mrst_cfg_tvalid", cfg_tvalid, 0);
    xk_tvalid = 1'b0;
    frame_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_idle", busy, 0);

    // 45 written frames: index climbs to FRAME_MAX then wraps to 0
    m_fc = 0;
    for (int i = 0; i < FRAME_MAX + 1; i++) begin
      m_fc = (m_fc + 1) % (FRAME_MAX + 1);
      run_frame(0, 1'b0, 1'b0, FFT_LEN - 1, FFT_LEN - 1, 0, 0, 0, 1'b1, RAM_BINS, m_fc, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
